// File: rtl/alu_arbiter_pkg.sv
// Shared opcodes, arbiter state encoding and small opcode helpers for the
// shared-ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  function automatic logic op_valid(input logic [2:0] m);
    return (m == OP_ADD) || (m == OP_SUB) || (m == OP_AND) || (m == OP_OR);
  endfunction

  // Only arithmetic ops produce a meaningful carry; the ALU leaves it stale otherwise.
  function automatic logic op_has_carry(input logic [2:0] m);
    return (m == OP_ADD) || (m == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// a tie goes to the requester currently holding priority.
module alu_arbiter_rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic       o_valid,
  output logic       o_idx
);

  assign o_valid = |i_req;
  assign o_idx   = (&i_req) ? i_prio : i_req[1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 8-bit ALU: latches a
// granted request, issues it for one cycle, captures the result, then acks.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8  // must match the ALU width; only 8 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       mode0,
  input  logic [2:0]       mode1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             res_zero,
  output logic             res_carry,
  output logic             err,
  output logic             busy,
  output logic             alu_enable,
  output logic [2:0]       alu_mode,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_flag_zero,
  input  logic             alu_flag_carry
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic             r_prio;
  logic             r_grant;
  logic             r_err;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic [2:0]       r_alu_mode;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;

  logic             w_pick_valid;
  logic             w_pick_idx;
  logic [2:0]       w_sel_mode;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_mode_ok;

  alu_arbiter_rr_pick2 u_pick (
    .i_req   ({req1, req0}),
    .i_prio  (r_prio),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_sel_mode = w_pick_idx ? mode1 : mode0;
  assign w_sel_a    = w_pick_idx ? a1    : a0;
  assign w_sel_b    = w_pick_idx ? b1    : b0;
  assign w_mode_ok  = op_valid(w_sel_mode);

  // Operand outputs hold their last issued value; only alu_enable qualifies them.
  assign alu_mode  = r_alu_mode;
  assign alu_in_a  = r_alu_a;
  assign alu_in_b  = r_alu_b;
  assign result    = r_result;
  assign res_zero  = r_zero;
  assign res_carry = r_carry;

  always_comb begin
    w_next     = r_state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    err        = 1'b0;
    alu_enable = 1'b0;
    busy       = (r_state != ARB_IDLE);
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) w_next = w_mode_ok ? ARB_ISSUE : ARB_DONE;
      end
      ARB_ISSUE: begin
        alu_enable = 1'b1;
        w_next     = ARB_WAIT;
      end
      ARB_WAIT: begin
        w_next = ARB_DONE;
      end
      ARB_DONE: begin
        ack0   = ~r_grant;
        ack1   = r_grant;
        err    = r_err;
        w_next = ARB_IDLE;
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_prio     <= 1'b0;
      r_grant    <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_alu_mode <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_idx;
            r_prio  <= ~w_pick_idx;
            r_err   <= ~w_mode_ok;
            if (w_mode_ok) begin
              r_alu_mode <= w_sel_mode;
              r_alu_a    <= w_sel_a;
              r_alu_b    <= w_sel_b;
            end else begin
              // Rejected op never touches the ALU; response is all-zero with err.
              r_result <= '0;
              r_zero   <= 1'b0;
              r_carry  <= 1'b0;
            end
          end
        end
        ARB_WAIT: begin
          r_result <= alu_out;
          r_zero   <= alu_flag_zero;
          r_carry  <= op_has_carry(r_alu_mode) ? alu_flag_carry : 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU device, transaction-level
// reference model, directed scenarios plus randomized two-requester traffic.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [2:0]   mode0, mode1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, res_zero, res_carry, err, busy, alu_enable;
  logic [W-1:0] result, alu_in_a, alu_in_b;
  logic [2:0]   alu_mode;
  logic [W-1:0] alu_out = 8'd0;
  logic         alu_flag_zero = 1'b0;
  logic         alu_flag_carry = 1'b0;

  int errors = 0;
  int checks = 0;
  int m_prio = 0;
  int en_cnt;

  typedef struct packed {
    logic       a0;
    logic       a1;
    logic       err;
    logic [7:0] res;
    logic       z;
    logic       c;
  } obs_t;

  obs_t obs_q[$];
  int   cyc_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result),
    .res_zero(res_zero), .res_carry(res_carry), .err(err), .busy(busy),
    .alu_enable(alu_enable), .alu_mode(alu_mode),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_flag_zero(alu_flag_zero), .alu_flag_carry(alu_flag_carry)
  );

  // Registered ALU device; carry is left stale by logic ops.
  int alu_s;
  always_comb begin
    alu_s = 0;
    case (alu_mode)
      OP_ADD:  alu_s = int'(alu_in_a) + int'(alu_in_b);
      OP_SUB:  alu_s = int'(alu_in_a) - int'(alu_in_b);
      OP_AND:  alu_s = int'(alu_in_a & alu_in_b);
      OP_OR:   alu_s = int'(alu_in_a | alu_in_b);
      default: alu_s = 0;
    endcase
  end

  always @(posedge clk) begin
    if (alu_enable) begin
      alu_out       <= alu_s[7:0];
      alu_flag_zero <= (alu_s[7:0] == 8'd0);
      if (alu_mode == OP_ADD) alu_flag_carry <= (alu_s > 255);
      else if (alu_mode == OP_SUB) alu_flag_carry <= (alu_s < 0);
    end
  end

  // Expected response seen by requester 'who' for one operation.
  function automatic obs_t exp_obs(input int who, input logic [2:0] m,
                                   input logic [7:0] a, input logic [7:0] b);
    obs_t o;
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    o = '0;
    o.a0 = (who == 0);
    o.a1 = (who == 1);
    case (m)
      OP_ADD: begin o.res = 8'((ua + ub) % 256);       o.c = ((ua + ub) >= 256); end
      OP_SUB: begin o.res = 8'((ua - ub + 256) % 256); o.c = (ua < ub); end
      OP_AND: o.res = a & b;
      OP_OR:  o.res = a | b;
      default: o.err = 1'b1;
    endcase
    o.z = !o.err && (o.res == 8'd0);
    return o;
  endfunction

  task automatic set_req(input int who, input logic [2:0] m,
                         input logic [7:0] a, input logic [7:0] b);
    if (who == 0) begin mode0 = m; a0 = a; b0 = b; req0 = 1'b1; end
    else          begin mode1 = m; a1 = a; b1 = b; req1 = 1'b1; end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 10 && busy; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // Steps the clock collecting acks; a requester drops req once acked unless hold.
  task automatic observe(input int n_acks, input int budget, input bit hold,
                         output bit timed_out);
    obs_t o;
    obs_q.delete();
    cyc_q.delete();
    en_cnt = 0;
    for (int k = 1; k <= budget && obs_q.size() < n_acks; k++) begin
      @(posedge clk); #1;
      if (alu_enable) en_cnt++;
      if (ack0 || ack1) begin
        o = {ack0, ack1, err, result, res_zero, res_carry};
        obs_q.push_back(o);
        cyc_q.push_back(k);
        if (!hold) begin
          if (ack0) req0 = 1'b0;
          if (ack1) req1 = 1'b0;
        end
      end
    end
    timed_out = (obs_q.size() < n_acks);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ack0, ack1, err, busy, alu_enable, res_zero, res_carry} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {ack0, ack1, err, busy, alu_enable, res_zero, res_carry});
    end
    checks++;
    if ({alu_mode, alu_in_a, alu_in_b, result} !== 27'b0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {alu_mode, alu_in_a, alu_in_b, result});
    end
    rst = 1'b0;
    m_prio = 0;
  endtask

  task automatic test_single_add();
    bit to;
    obs_t e;
    wait_idle();
    set_req(0, OP_ADD, 8'd200, 8'd100);
    e = exp_obs(0, OP_ADD, 8'd200, 8'd100);
    observe(1, 10, 1'b0, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_add_timeout: got no ack required ack0"); return; end
    m_prio = 1;
    checks++;
    if (obs_q[0] !== e) begin
      errors++; $display("FAIL single_add_resp: got %h required %h", obs_q[0], e);
    end
    checks++;
    if (cyc_q[0] != 3) begin
      errors++; $display("FAIL single_add_latency: got %0d required 3", cyc_q[0]);
    end
    checks++;
    if (en_cnt != 1) begin
      errors++; $display("FAIL single_add_enables: got %0d required 1", en_cnt);
    end
  endtask

  task automatic test_zero_result();
    bit to;
    obs_t e;
    wait_idle();
    set_req(1, OP_SUB, 8'd5, 8'd5);
    e = exp_obs(1, OP_SUB, 8'd5, 8'd5);
    observe(1, 10, 1'b0, to);
    checks++;
    if (to) begin errors++; $display("FAIL zero_timeout: got no ack required ack1"); return; end
    m_prio = 0;
    checks++;
    if (obs_q[0] !== e) begin
      errors++; $display("FAIL zero_resp: got %h required %h", obs_q[0], e);
    end
    checks++;
    if (cyc_q[0] != 3) begin
      errors++; $display("FAIL zero_latency: got %0d required 3", cyc_q[0]);
    end
  endtask

  task automatic test_carry_mask();
    bit to;
    obs_t e;
    wait_idle();
    set_req(0, OP_SUB, 8'd3, 8'd5);
    e = exp_obs(0, OP_SUB, 8'd3, 8'd5);
    observe(1, 10, 1'b0, to);
    checks++;
    if (to || obs_q[0] !== e) begin
      errors++; $display("FAIL borrow_resp: got %h required %h", to ? obs_t'('0) : obs_q[0], e);
    end
    m_prio = 1;
    wait_idle();
    set_req(1, OP_AND, 8'hF0, 8'h0F);
    e = exp_obs(1, OP_AND, 8'hF0, 8'h0F);
    observe(1, 10, 1'b0, to);
    checks++;
    if (to || obs_q[0] !== e) begin
      errors++; $display("FAIL and_carry_mask: got %h required %h", to ? obs_t'('0) : obs_q[0], e);
    end
    m_prio = 0;
  endtask

  task automatic test_contention();
    bit to;
    obs_t e;
    int p;
    wait_idle();
    set_req(0, OP_OR, 8'h0F, 8'hF0);
    set_req(1, OP_ADD, 8'd1, 8'd1);
    observe(4, 30, 1'b1, to);
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (to) begin
      errors++; $display("FAIL contention_timeout: got %0d acks required 4", obs_q.size());
      return;
    end
    p = m_prio;
    for (int i = 0; i < 4; i++) begin
      e = (p == 0) ? exp_obs(0, OP_OR, 8'h0F, 8'hF0) : exp_obs(1, OP_ADD, 8'd1, 8'd1);
      checks++;
      if (obs_q[i] !== e) begin
        errors++; $display("FAIL contention_ack%0d: got %h required %h", i, obs_q[i], e);
      end
      checks++;
      if (cyc_q[i] != 3 + 4 * i) begin
        errors++; $display("FAIL contention_cycle%0d: got %0d required %0d", i, cyc_q[i], 3 + 4 * i);
      end
      p = 1 - p;
    end
    m_prio = p;
  endtask

  task automatic test_invalid_mode();
    bit to;
    obs_t e;
    logic [2:0] m;
    wait_idle();
    m = 3'($urandom_range(7, 4));
    set_req(0, m, 8'($urandom), 8'($urandom));
    e = exp_obs(0, m, a0, b0);
    observe(1, 10, 1'b0, to);
    checks++;
    if (to) begin errors++; $display("FAIL invalid_timeout: got no ack required ack0"); return; end
    m_prio = 1;
    checks++;
    if (obs_q[0] !== e) begin
      errors++; $display("FAIL invalid_resp: got %h required %h", obs_q[0], e);
    end
    checks++;
    if (cyc_q[0] != 1 || en_cnt != 0) begin
      errors++; $display("FAIL invalid_timing: got cycle=%0d enables=%0d required cycle=1 enables=0",
                         cyc_q[0], en_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    bit to;
    obs_t e0, e1;
    wait_idle();
    set_req(0, OP_ADD, 8'd10, 8'd20);
    @(posedge clk); #1;
    checks++;
    if (alu_enable !== 1'b1 || alu_in_a !== 8'd10 || alu_in_b !== 8'd20) begin
      errors++; $display("FAIL issue_drive: got en=%b a=%h b=%h required en=1 a=0a b=14",
                         alu_enable, alu_in_a, alu_in_b);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, err, busy, alu_enable, res_zero, res_carry} !== 7'b0 ||
        {alu_mode, alu_in_a, alu_in_b, result} !== 27'b0) begin
      errors++; $display("FAIL reset_wait_async: got ctrl=%b data=%h required 0",
                         {ack0, ack1, err, busy, alu_enable, res_zero, res_carry},
                         {alu_mode, alu_in_a, alu_in_b, result});
    end
    req0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL reset_wait_noack: got %b%b required 00", ack0, ack1);
    end
    rst = 1'b0;
    m_prio = 0;
    set_req(0, OP_OR, 8'($urandom), 8'($urandom));
    set_req(1, OP_SUB, 8'($urandom), 8'($urandom));
    e0 = exp_obs(0, OP_OR, a0, b0);
    e1 = exp_obs(1, OP_SUB, a1, b1);
    observe(2, 20, 1'b0, to);
    checks++;
    if (to || obs_q[0] !== e0 || obs_q[1] !== e1) begin
      errors++; $display("FAIL reset_wait_reissue: got %0d acks first=%h required first=%h second=%h",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : obs_t'('0), e0, e1);
    end
    m_prio = 0;
  endtask

  task automatic test_random();
    bit to;
    int pat, n, n_valid, who;
    logic [2:0] md[2];
    logic [7:0] aa[2], bb[2];
    obs_t exp_q[$];
    for (int r = 0; r < 25; r++) begin
      wait_idle();
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      pat = $urandom_range(3, 1);
      exp_q.delete();
      n_valid = 0;
      for (int i = 0; i < 2; i++) begin
        md[i] = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3, 0));
        aa[i] = 8'($urandom);
        bb[i] = 8'($urandom);
        if (pat[i]) begin
          set_req(i, md[i], aa[i], bb[i]);
          if (op_valid(md[i])) n_valid++;
        end
      end
      if (pat == 3) begin
        who = m_prio;
        exp_q.push_back(exp_obs(who, md[who], aa[who], bb[who]));
        who = 1 - who;
        exp_q.push_back(exp_obs(who, md[who], aa[who], bb[who]));
      end else begin
        who = (pat == 2) ? 1 : 0;
        exp_q.push_back(exp_obs(who, md[who], aa[who], bb[who]));
      end
      m_prio = 1 - who;
      n = exp_q.size();
      observe(n, 20, 1'b0, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL rand%0d_timeout: got %0d acks required %0d", r, obs_q.size(), n);
        req0 = 1'b0;
        req1 = 1'b0;
        continue;
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_ack%0d: got %h required %h", r, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (en_cnt != n_valid) begin
        errors++; $display("FAIL rand%0d_enables: got %0d required %0d", r, en_cnt, n_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        errors++; $display("FAIL rand%0d_idle: got busy=%b ack=%b%b required 0 00", r, busy, ack0, ack1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    mode0 = 3'd0; mode1 = 3'd0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single_add();
    test_zero_result();
    test_carry_mask();
    test_contention();
    test_invalid_mode();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-bit ALU. Accepts operation requests (mode, operands) from two requesters, such as the execute stage and the address/branch unit. Drives the ALU's enable, mode and operand inputs for exactly one cycle per transaction, then captures the registered result and flags. Returns them to the granted requester with a one-cycle acknowledge. Sits between the core's control logic and the ALU instance; it is the only driver of the ALU inputs.

## Interface
- WIDTH, 8, data width; must equal the ALU width (only 8 supported)
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request level; held high with operands stable until matching ack
- mode0 / mode1  in  3  operation code (`OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`)
- a0, b0 / a1, b1  in  WIDTH  operands
- ack0 / ack1  out  1  one-cycle completion strobe for the requester
- result  out  WIDTH  shared response data, valid while either ack is high
- res_zero, res_carry  out  1  response flags, valid with ack
- err  out  1  high with ack when the mode was not one of the four OP_* codes
- busy  out  1  high in any state other than IDLE
- alu_enable  out  1  ALU enable
- alu_mode  out  3  ALU mode
- alu_in_a, alu_in_b  out  WIDTH  ALU operands
- alu_out  in  WIDTH  ALU result
- alu_flag_zero, alu_flag_carry  in  1  ALU flags

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE. Invalid mode path: IDLE → DONE, with no ALU access.
- **IDLE:** sample req0/req1 at posedge.
  - One requester: grant it.
  - Both requesters: grant the one holding priority.
  - On grant, latch mode/a/b into internal regs and record the grant index.
  - Priority pointer flips to the other requester after every grant. Reset priority is requester 0.
- **ISSUE:** alu_enable=1, alu_mode/alu_in_a/alu_in_b driven from the latched regs. The ALU computes on this cycle's closing edge.
- **WAIT:** alu_enable=0. At the closing edge, capture alu_out into result and alu_flag_zero into res_zero.
  - For ADD/SUB, capture alu_flag_carry into res_carry.
  - For AND/OR, force res_carry=0; the ALU keeps a stale carry for logic ops.
- **DONE:** ack of the granted requester is high for exactly this cycle; result/flags held.
- **err path:** an invalid mode goes IDLE → DONE with err=1, result=0, res_zero=0, res_carry=0, and alu_enable never asserted.
- Requests are only sampled in IDLE. A req held high past its DONE cycle is a new transaction.
- A req that drops before grant is ignored; no ack is produced.
- The ALU operand outputs hold their last value outside ISSUE; only alu_enable qualifies them.

## Timing
- **Reset:** state IDLE, priority=0, ack0=ack1=0, err=0, busy=0, alu_enable=0, alu_mode/alu_in_a/alu_in_b=0, result=0, res_zero=0, res_carry=0.
- **Latency:** req sampled at edge E; ISSUE during E..E+1; WAIT during E+1..E+2; ack high during E+2..E+3.
  - Throughput: one op per 4 cycles; back-to-back from alternating requesters is possible.
  - Invalid mode: ack during E..E+1 (after the grant edge).
- **Requester handshake:** a registered requester drops req at the edge ending its ack cycle. The next IDLE therefore sees only genuinely new requests.
- **Simultaneous requests:** alternate strictly. Both held continuously gives grant order 0,1,0,1...
- **Reset mid-transaction:** async return to reset values. No ack for the aborted op; the requester must reissue. alu_enable drops immediately.
- No combinational path from req* to ack* or alu_*.

## Structure
- `OP_*` codes come from the existing shared parameters.v.
- Add FSM state defines (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_DONE`) to parameters.v so the bench can peek state.
- Optional sub-module rr_pick2: a combinational 2-way round-robin pick from {req, priority}. Everything else is flat in alu_arbiter.

## Test plan
- **Single ADD:** req0, `OP_ADD`, a0=200, b0=100 → ack0 after 3 edges; result=44, res_carry=1, res_zero=0; one alu_enable pulse.
- **Zero result:** req1, `OP_SUB`, 5−5 → ack1; result=0, res_zero=1, res_carry=0.
- **Carry masking:** `OP_SUB` 3−5 → result=0xFE, res_carry=1. Then `OP_AND` 0xF0&0x0F → result=0, res_zero=1, res_carry=0 (masked).
- **Contention:** req0 and req1 held continuously (`OP_OR` 0x0F|0xF0 and `OP_ADD` 1+1) → acks alternate 0,1,0,1 every 4 cycles; results 0xFF and 2.
- **Invalid mode:** req0 with a mode outside the four OP_* codes → ack0 with err=1, result=0; alu_enable never high.
- **Reset in WAIT:** assert rst during WAIT → all outputs at reset values immediately; no ack. After release, a re-issued request completes normally with priority restored to requester 0.
